pipelined_alu_core: RTL

- Parametrised successor to the fixed 32-bit free-running logic/arithmetic block.
- One opcode-selected operation per transaction on WIDTH-bit operands A, B, C, instead of computing every function every cycle.
- Two-stage elastic pipeline with valid/ready handshakes on both sides, result flags, a pass-through tag, and a completed-operation counter.
- Sits between an operand issue stage and a result writeback/compare stage in the reversible-vs-conventional ALU comparison datapath.

---
 rtl/pipelined_alu_core.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_alu_core.sv
// Two-stage elastic ALU: stage 1 captures operands on the input handshake,
// stage 2 evaluates the opcode and holds result, flags and tag for downstream.
module pipelined_alu_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [3:0] OP_MUX1  = 4'd0;
  localparam logic [3:0] OP_MUX2  = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_ADD1  = 4'd5;
  localparam logic [3:0] OP_PERES = 4'd6;
  localparam logic [3:0] OP_NAND  = 4'd7;
  localparam logic [3:0] OP_NOR   = 4'd8;
  localparam logic [3:0] OP_ADD   = 4'd9;
  localparam logic [3:0] OP_SUB   = 4'd10;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s2_adv_c;
  logic             s1_adv_c;
  logic [SUM_W-1:0] sum_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             err_c;

  assign s2_adv_c = ~s2_valid_q | out_ready;
  assign s1_adv_c = ~s1_valid_q | s2_adv_c;

  // Opcode evaluation on the stage-1 operands; arithmetic is one bit wider for carry.
  always_comb begin
    sum_c   = '0;
    res_c   = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    case (s1_op_q)
      OP_MUX1:  res_c = (s1_a_q & s1_b_q) | (~s1_a_q & s1_c_q);
      OP_MUX2:  res_c = (s1_a_q & s1_c_q) | (~s1_a_q & s1_b_q);
      OP_XOR:   res_c = s1_a_q ^ s1_b_q;
      OP_AND:   res_c = s1_a_q & s1_b_q;
      OP_OR:    res_c = s1_a_q | s1_b_q;
      OP_ADD1: begin
        sum_c   = {1'b0, s1_a_q} + {1'b0, s1_b_q} + SUM_W'(1);
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
      end
      OP_PERES: res_c = (s1_a_q & s1_b_q) ^ s1_c_q;
      OP_NAND:  res_c = ~(s1_a_q & s1_b_q);
      OP_NOR:   res_c = ~(s1_a_q | s1_b_q);
      OP_ADD: begin
        sum_c   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
      end
      OP_SUB: begin
        sum_c   = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + SUM_W'(1);
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
      end
      default:  err_c = 1'b1;
    endcase
  end

  // Pipeline advance: each stage loads only when its downstream slot frees up.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    tag_d      = tag_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d  = in_op;
        s1_a_d   = in_a;
        s1_b_d   = in_b;
        s1_c_d   = in_c;
        s1_tag_d = in_tag;
      end
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res_c;
        tag_d    = s1_tag_q;
        zero_d   = (res_c == '0);
        carry_d  = carry_c;
        err_d    = err_c;
      end
    end

    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      tag_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = s1_adv_c;
  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign out_err    = err_q;
  assign op_count   = cnt_q;

endmodule
